// File: rtl/hamming74_serial_decoder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | hamming74_serial_decoder_pkg: Hamming(7,4) positions and types   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package hamming74_serial_decoder_pkg;

    localparam int CW_LEN   = 7;
    localparam int DATA_LEN = 4;

    // Zero-based positions in the codeword; word[i] holds wire position i+1.
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D1 = 2;
    localparam int P3 = 3;
    localparam int D2 = 4;
    localparam int D3 = 5;
    localparam int D4 = 6;

    typedef logic [CW_LEN-1:0]   codeword_t;
    typedef logic [DATA_LEN-1:0] nibble_t;

    // data[0] is d1, data[3] is d4.
    typedef struct packed {
        nibble_t    data;
        logic [2:0] syndrome;
        logic       err;
    } fix_t;

    function automatic logic [2:0] calc_syndrome(input codeword_t w);
        logic s1;
        logic s2;
        logic s3;
        s1 = w[P1] ^ w[D1] ^ w[D2] ^ w[D4];
        s2 = w[P2] ^ w[D1] ^ w[D3] ^ w[D4];
        s3 = w[P3] ^ w[D2] ^ w[D3] ^ w[D4];
        return {s3, s2, s1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming74_serial_decoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | hamming74_serial_decoder_if: serial channel in, decoded bits out |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface hamming74_serial_decoder_if #(
    parameter int CNT_W = 16
) ();

    logic             rx_bit;
    logic             rx_valid;
    logic             align;
    logic             dec_bit;
    logic             dec_valid;
    logic             err_pulse;
    logic [CNT_W-1:0] cw_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output rx_bit,
        output rx_valid,
        output align,
        input  dec_bit,
        input  dec_valid,
        input  err_pulse,
        input  cw_count,
        input  err_count
    );

    modport slave (
        input  rx_bit,
        input  rx_valid,
        input  align,
        output dec_bit,
        output dec_valid,
        output err_pulse,
        output cw_count,
        output err_count
    );

endinterface
`default_nettype wire

// File: rtl/hamming74_syndrome_fix.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | hamming74_syndrome_fix: combinational syndrome + 1-bit correction|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hamming74_syndrome_fix
    import hamming74_serial_decoder_pkg::*;
(
    input  codeword_t word,
    output fix_t      fix
);

    logic [2:0] w_syndrome;
    codeword_t  w_flip;
    codeword_t  w_corrected;

    always_comb begin
        w_syndrome = calc_syndrome(word);
        w_flip     = '0;
        for (int i = 0; i < CW_LEN; i++) begin
            w_flip[i] = (w_syndrome == 3'(i + 1));
        end
        w_corrected = word ^ w_flip;

        fix.data     = {w_corrected[D4], w_corrected[D3], w_corrected[D2], w_corrected[D1]};
        fix.syndrome = w_syndrome;
        fix.err      = |w_syndrome;
    end

endmodule
`default_nettype wire

// File: rtl/hamming74_serial_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | hamming74_serial_decoder: frames serial Hamming(7,4) codewords,  |
// | corrects single errors, streams d1..d4 out. Rev 1.0              |
// +------------------------------------------------------------------+
module hamming74_serial_decoder
    import hamming74_serial_decoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    hamming74_serial_decoder_if.slave   bus
);

    localparam logic [2:0] c_LAST_IDX = 3'(CW_LEN - 1);

    logic [2:0]        r_idx;
    logic [CW_LEN-2:0] r_buf;
    logic [2:0]        r_shift;
    logic [1:0]        r_left;
    logic              r_dec_bit;
    logic              r_dec_valid;
    logic              r_err_pulse;
    logic [CNT_W-1:0]  r_cw_count;
    logic [CNT_W-1:0]  r_err_count;

    logic [2:0]        w_pos;
    logic              w_done;
    codeword_t         w_word;
    fix_t              w_fix;

    // align restarts framing, so a bit arriving with it lands in position 1.
    always_comb begin
        w_pos  = bus.align ? 3'd0 : r_idx;
        w_done = bus.rx_valid && !bus.align && (r_idx == c_LAST_IDX);
        w_word = {bus.rx_bit, r_buf};
    end

    hamming74_syndrome_fix u_fix (
        .word (w_word),
        .fix  (w_fix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= 3'd0;
            r_buf <= '0;
        end else begin
            if (bus.rx_valid && !w_done) begin
                r_buf[w_pos] <= bus.rx_bit;
            end
            if (bus.align) begin
                r_idx <= bus.rx_valid ? 3'd1 : 3'd0;
            end else if (bus.rx_valid) begin
                r_idx <= w_done ? 3'd0 : r_idx + 3'd1;
            end
        end
    end

    // d1 goes out directly; d2..d4 are parked in r_shift and drained one per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift     <= '0;
            r_left      <= 2'd0;
            r_dec_bit   <= 1'b0;
            r_dec_valid <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_done && w_fix.err;
            if (w_done) begin
                r_dec_bit   <= w_fix.data[0];
                r_dec_valid <= 1'b1;
                r_shift     <= w_fix.data[DATA_LEN-1:1];
                r_left      <= 2'(DATA_LEN - 1);
            end else if (r_left != 2'd0) begin
                r_dec_bit   <= r_shift[0];
                r_dec_valid <= 1'b1;
                r_shift     <= {1'b0, r_shift[2:1]};
                r_left      <= r_left - 2'd1;
            end else begin
                r_dec_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cw_count  <= '0;
            r_err_count <= '0;
        end else if (w_done) begin
            if (r_cw_count != '1) begin
                r_cw_count <= r_cw_count + 1'b1;
            end
            if ((w_fix.syndrome != 3'd0) && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign bus.dec_bit   = r_dec_bit;
    assign bus.dec_valid = r_dec_valid;
    assign bus.err_pulse = r_err_pulse;
    assign bus.cw_count  = r_cw_count;
    assign bus.err_count = r_err_count;

endmodule
`default_nettype wire
